// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding one shared UART transmitter.
// A granted requester keeps the transmitter locked until its packet ends
// or its request stays low for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req,
  input  logic [3:0]              last,
  input  logic [4*DATA_WIDTH-1:0] data_in,
  input  logic                    tx_busy,
  output logic [3:0]              ack,
  output logic [3:0]              grant,
  output logic                    tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    idle
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, START_WAIT, DONE_WAIT} state_t;

  state_t                  state, state_nx;
  logic [1:0]              ptr, ptr_nx;
  logic [1:0]              owner, owner_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    last_flag, last_flag_nx;
  logic [3:0]              grant_nx, ack_nx;
  logic                    tx_start_nx;
  logic [DATA_WIDTH-1:0]   tx_data_nx;
  logic [1:0]              rr_pick;
  logic                    rr_hit;

  assign idle = (state == IDLE);

  // First requesting index after the most recent owner, wrapping mod 4.
  always_comb begin
    rr_pick = ptr;
    rr_hit  = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!rr_hit && req[2'(ptr + k)]) begin
        rr_pick = 2'(ptr + k);
        rr_hit  = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the packet-lock FSM.
  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    ack_nx       = '0;
    tx_start_nx  = 1'b0;
    tx_data_nx   = tx_data;
    ptr_nx       = ptr;
    owner_nx     = owner;
    cnt_nx       = '0;
    last_flag_nx = last_flag;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          owner_nx = rr_pick;
          grant_nx = 4'b0001 << rr_pick;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (req[owner] && !tx_busy) begin
          tx_data_nx         = data_in[owner*DATA_WIDTH +: DATA_WIDTH];
          tx_start_nx        = 1'b1;
          ack_nx[owner]      = 1'b1;
          last_flag_nx       = last[owner];
          state_nx           = START_WAIT;
        end else if (!req[owner] && !tx_busy) begin
          // Release lands on the edge that ends the LOCK_TIMEOUT-th idle cycle.
          if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            grant_nx = '0;
            ptr_nx   = owner;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      START_WAIT: begin
        if (tx_busy) state_nx = DONE_WAIT;
      end
      DONE_WAIT: begin
        if (!tx_busy) begin
          if (last_flag) begin
            grant_nx = '0;
            ptr_nx   = owner;
            state_nx = IDLE;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      ack       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      ptr       <= 2'd3;
      owner     <= '0;
      cnt       <= '0;
      last_flag <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      ack       <= ack_nx;
      tx_start  <= tx_start_nx;
      tx_data   <= tx_data_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      cnt       <= cnt_nx;
      last_flag <= last_flag_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model plus scoreboard,
// requester queues and a busy-for-N-cycles transmitter model.
module tb_uart_tx_arbiter;
  localparam int DW = 8;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [3:0]    req      = '0;
  logic [3:0]    last     = '0;
  logic [4*DW-1:0] data_in = '0;
  logic          tx_busy  = 1'b0;
  logic [3:0]    ack, grant;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          idle;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .data_in(data_in),
    .tx_busy(tx_busy), .ack(ack), .grant(grant), .tx_start(tx_start),
    .tx_data(tx_data), .idle(idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester byte queues: {last, byte} entries, head/tail counters.
  logic [8:0] mem [4][32];
  int         head [4] = '{default: 0};
  int         tail [4] = '{default: 0};
  logic [3:0] en = '0;

  // Expected transmissions: {requester id, byte}.
  logic [9:0] expq [$];
  int         mptr = 3;

  int         busy_len = 10;
  int         bcnt = 0;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       rst_q = 1'b1;
  logic       busy_q = 1'b0;
  logic [DW-1:0] exp_tx_data = '0;
  logic [3:0] gacc = '0;
  int         nstart = 0;
  logic [3:0] gseq [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh_inputs();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && head[i] != tail[i]) begin
        req[i] = 1'b1;
        last[i] = mem[i][head[i] % 32][8];
        data_in[i*DW +: DW] = mem[i][head[i] % 32][7:0];
      end else begin
        req[i] = 1'b0;
        last[i] = 1'b0;
        data_in[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic enq(input int i, input logic lst, input logic [7:0] b);
    mem[i][tail[i] % 32] = {lst, b};
    tail[i]++;
  endtask

  task automatic set_force(input logic v);
    force_busy = v;
    tx_busy = force_busy | model_busy;
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < 4; i++) if (en[i] && head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  // Whole packets served in round-robin order after the previous owner.
  task automatic model_build();
    int h [4];
    int pick;
    logic [8:0] e;
    for (int i = 0; i < 4; i++) h[i] = head[i];
    forever begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        int i = (mptr + k) % 4;
        if (pick < 0 && en[i] && h[i] != tail[i]) pick = i;
      end
      if (pick < 0) break;
      do begin
        e = mem[pick][h[pick] % 32];
        h[pick]++;
        expq.push_back({2'(pick), e[7:0]});
      end while (!e[8] && h[pick] != tail[pick]);
      mptr = pick;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((expq.size() != 0 || !idle || tx_busy || pending()) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_in_time"}, 32'(n < budget), 32'd1);
    check({name, "_drained"}, expq.size(), 32'd0);
    check({name, "_idle"}, idle, 32'd1);
  endtask

  // Requester and transmitter models react just after each edge.
  initial forever begin
    @(posedge clk);
    rst_q  = reset;
    busy_q = tx_busy;
    #1;
    for (int i = 0; i < 4; i++) if (ack[i] && head[i] != tail[i]) head[i]++;
    if (tx_start) bcnt = busy_len;
    model_busy = (bcnt > 0);
    if (bcnt > 0) bcnt--;
    tx_busy = force_busy | model_busy;
    refresh_inputs();
  end

  // Compare process: every cycle on the falling edge.
  initial begin
    logic [9:0] e;
    int id;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        exp_tx_data = '0;
        check("reset_state", {14'b0, grant, ack, tx_start, idle, tx_data},
              {14'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00});
      end else if (tx_start || ack != 4'b0000) begin
        if (expq.size() == 0) begin
          check("unexpected_start", {27'b0, ack, tx_start}, 32'd0);
        end else begin
          e  = expq.pop_front();
          id = int'(e[9:8]);
          check("start_pulse", {27'b0, ack, tx_start}, {27'b0, 4'(4'b0001 << id), 1'b1});
          check("start_grant", {28'b0, grant}, {28'b0, 4'(4'b0001 << id)});
          check("start_data", {24'b0, tx_data}, {24'b0, e[7:0]});
          check("start_not_busy", {31'b0, busy_q}, 32'd0);
          exp_tx_data = e[7:0];
          gseq[nstart % 16] = grant;
          nstart++;
        end
      end else begin
        check("tx_data_hold", {24'b0, tx_data}, {24'b0, exp_tx_data});
      end
      if (!rst_q) gacc |= grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] want [5];
    int n;
    int spur;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requesters pending; first grant goes to requester 0.
    for (int i = 0; i < 4; i++) enq(i, 1'b1, 8'(8'h10 + i));
    en = 4'b1111;
    mptr = 3;
    model_build();
    refresh_inputs();
    tick(2);
    check("reset_hold", {26'b0, grant, tx_start, idle}, {26'b0, 4'b0000, 1'b0, 1'b1});
    reset = 1'b0;
    tick(1);
    check("first_grant", {28'b0, grant}, 32'b0001);
    check("first_not_idle", {31'b0, idle}, 32'd0);
    wait_drain("rr_reset", 300);

    // All four requesting single-byte packets: strict rotation.
    busy_len = 3;
    nstart = 0;
    gacc = '0;
    en = '0;
    for (int i = 0; i < 4; i++) begin
      enq(i, 1'b1, 8'(8'h20 + 2*i));
      enq(i, 1'b1, 8'(8'h21 + 2*i));
    end
    en = 4'b1111;
    model_build();
    refresh_inputs();
    wait_drain("rr_all", 300);
    check("rr_count", nstart, 32'd8);
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_seq%0d", k), {28'b0, gseq[k]}, {28'b0, want[k]});
    check("rr_gacc", {28'b0, gacc}, 32'b1111);

    // Owner 1 stalls mid-packet while requester 3 waits: lock times out.
    busy_len = 2;
    en = '0;
    enq(1, 1'b0, 8'h51);
    enq(3, 1'b1, 8'h73);
    expq.push_back({2'd1, 8'h51});
    expq.push_back({2'd3, 8'h73});
    en = 4'b1010;
    refresh_inputs();
    tick(1);
    check("to_grant1", {28'b0, grant}, 32'b0010);
    n = 0;
    while (grant != 4'b0000 && n < 40) begin
      tick(1);
      n++;
    end
    check("to_cycles", n, 32'd12);
    tick(1);
    check("to_grant3", {28'b0, grant}, 32'b1000);
    mptr = 3;
    wait_drain("timeout", 100);

    // Requester 2 alone, three-byte packet, slow transmitter.
    busy_len = 10;
    nstart = 0;
    gacc = '0;
    en = '0;
    enq(2, 1'b0, 8'hA1);
    enq(2, 1'b0, 8'hA2);
    enq(2, 1'b1, 8'hA3);
    en = 4'b0100;
    model_build();
    refresh_inputs();
    tick(1);
    check("lat_grant", {28'b0, grant}, 32'b0100);
    tick(1);
    check("lat_start", {19'b0, tx_start, ack, tx_data}, {19'b0, 1'b1, 4'b0100, 8'hA1});
    wait_drain("single", 200);
    check("single_count", nstart, 32'd3);
    check("single_gacc", {28'b0, gacc}, 32'b0100);

    // Transmitter busy for 20 cycles while in LOAD: no pulse, no timeout.
    busy_len = 3;
    set_force(1'b1);
    en = '0;
    enq(0, 1'b0, 8'h01);
    enq(0, 1'b1, 8'h02);
    en = 4'b0001;
    model_build();
    refresh_inputs();
    tick(1);
    check("busy_grant", {28'b0, grant}, 32'b0001);
    spur = 0;
    repeat (20) begin
      tick(1);
      if (tx_start || ack != 4'b0000) spur++;
    end
    check("busy_no_start", spur, 32'd0);
    check("busy_no_timeout", {28'b0, grant}, 32'b0001);
    set_force(1'b0);
    tick(1);
    check("busy_release", {19'b0, tx_start, ack, tx_data}, {19'b0, 1'b1, 4'b0001, 8'h01});
    wait_drain("busy", 100);

    // Reset while waiting for the transmitter mid-packet.
    busy_len = 6;
    en = '0;
    enq(2, 1'b0, 8'hC1);
    enq(2, 1'b0, 8'hC2);
    enq(2, 1'b1, 8'hC3);
    en = 4'b0100;
    model_build();
    refresh_inputs();
    n = 0;
    while (!tx_start && n < 20) begin
      tick(1);
      n++;
    end
    check("dw_start_seen", {31'b0, tx_start}, 32'd1);
    tick(1);
    reset = 1'b1;
    en = '0;
    for (int i = 0; i < 4; i++) head[i] = tail[i];
    expq.delete();
    mptr = 3;
    refresh_inputs();
    tick(1);
    check("dw_reset", {22'b0, idle, grant, ack, tx_start}, {22'b0, 1'b1, 4'b0000, 4'b0000, 1'b0});
    reset = 1'b0;
    enq(0, 1'b1, 8'h0A);
    enq(2, 1'b1, 8'h2B);
    en = 4'b0101;
    model_build();
    refresh_inputs();
    tick(1);
    check("post_reset_grant", {28'b0, grant}, 32'b0001);
    wait_drain("post_reset", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
